// File: rtl/s_smp_io.sv
// S-SMP I/O register block: the $00F0-$00FF window seen by the SPC700.
// It holds the CPU-to-APU mailbox ports, the DSP register link, the
// CONTROL/IPL switch and three prescaled timers with 4-bit read-to-clear
// output counters.
module s_smp_io #(
  parameter int T01_DIV = 128,
  parameter int T2_DIV  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_en,
  input  logic [15:0] s_addr,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [7:0]  s_wdata,
  output logic [7:0]  s_rdata,
  output logic        s_sel,
  input  logic [1:0]  m_port,
  input  logic        m_read,
  input  logic        m_write,
  input  logic [7:0]  m_wdata,
  output logic [7:0]  m_rdata,
  output logic [7:0]  dsp_addr,
  output logic        dsp_write,
  output logic [7:0]  dsp_wdata,
  input  logic [7:0]  dsp_rdata,
  output logic        ipl_en
);

  localparam int PW = (T01_DIV > 1) ? $clog2(T01_DIV) : 1;
  localparam logic [PW-1:0] T01_LAST = PW'(T01_DIV - 1);
  localparam logic [PW-1:0] T2_MASK  = PW'(T2_DIV - 1);

  // Architectural state
  logic [7:0]    test_q,      test_d;
  logic [7:0]    control_q,   control_d;
  logic [7:0]    dspaddr_q,   dspaddr_d;
  logic [7:0]    aux0_q,      aux0_d;
  logic [7:0]    aux1_q,      aux1_d;
  logic [7:0]    in_q   [4];
  logic [7:0]    in_d   [4];
  logic [7:0]    out_q  [4];
  logic [7:0]    out_d  [4];
  logic [7:0]    target_q [3];
  logic [7:0]    target_d [3];
  logic [7:0]    stage2_q [3];
  logic [7:0]    stage2_d [3];
  logic [3:0]    cnt_q    [3];
  logic [3:0]    cnt_d    [3];
  logic [PW-1:0] presc_q,     presc_d;
  logic          dsp_write_q, dsp_write_d;
  logic [7:0]    dsp_wdata_q, dsp_wdata_d;

  // Access decode
  logic        s_act;
  logic        s_wr;
  logic        s_rd;
  logic [3:0]  reg_idx;
  logic [15:0] wr_sel;
  logic [2:0]  tick;
  logic [2:0]  rise;
  logic [2:0]  inc;
  logic [2:0]  hit;
  logic [2:0]  rd_clr;
  logic [7:0]  s2_inc [3];
  logic [7:0]  rdata;
  logic        unused_ok;

  assign s_sel   = (s_addr[15:4] == 12'h00F);
  assign s_act   = cpu_en & s_sel;
  assign s_wr    = s_act & s_write;
  assign s_rd    = s_act & s_read;
  assign reg_idx = s_addr[3:0];
  assign wr_sel  = s_wr ? (16'h0001 << reg_idx) : 16'h0000;

  // TEST contents and the unused CONTROL bits have no readback path.
  assign unused_ok = ^{m_read, test_q, control_q[6:3]};

  // Stage-1 ticks: timers 0/1 on the prescaler wrap, timer 2 on every
  // wrap of its low bits; both only on a cpu_en cycle.
  always_comb begin
    tick[0] = cpu_en & (presc_q == T01_LAST);
    tick[1] = cpu_en & (presc_q == T01_LAST);
    tick[2] = cpu_en & ((presc_q & T2_MASK) == T2_MASK);
  end

  // Next-state for registers, mailbox latches and the DSP write pulse.
  always_comb begin
    test_d      = wr_sel[0] ? s_wdata : test_q;
    control_d   = wr_sel[1] ? s_wdata : control_q;
    dspaddr_d   = wr_sel[2] ? s_wdata : dspaddr_q;
    aux0_d      = wr_sel[8] ? s_wdata : aux0_q;
    aux1_d      = wr_sel[9] ? s_wdata : aux1_q;
    dsp_write_d = wr_sel[3];
    dsp_wdata_d = wr_sel[3] ? s_wdata : dsp_wdata_q;
    presc_d     = cpu_en ? (presc_q + PW'(1)) : presc_q;
    for (int p = 0; p < 4; p++) begin
      // A main-CPU write to a port beats a same-cycle CONTROL clear.
      if (m_write && (m_port == 2'(p))) begin
        in_d[p] = m_wdata;
      end else if (wr_sel[1] && s_wdata[4 + (p / 2)]) begin
        in_d[p] = 8'h00;
      end else begin
        in_d[p] = in_q[p];
      end
      out_d[p] = wr_sel[4 + p] ? s_wdata : out_q[p];
    end
    for (int t = 0; t < 3; t++) begin
      target_d[t] = wr_sel[10 + t] ? s_wdata : target_q[t];
    end
  end

  // Timer stage-2 and output counters, including enable-edge restart
  // and read-to-clear that still keeps a coincident increment.
  always_comb begin
    for (int t = 0; t < 3; t++) begin
      rise[t]   = wr_sel[1] & s_wdata[t] & ~control_q[t];
      inc[t]    = control_q[t] & tick[t];
      s2_inc[t] = stage2_q[t] + 8'd1;
      // 8-bit wrap makes a target of 0 behave as 256.
      hit[t]    = inc[t] & (s2_inc[t] == target_q[t]);
      rd_clr[t] = s_rd & (reg_idx == 4'(13 + t));

      if (rise[t]) begin
        stage2_d[t] = 8'h00;
      end else if (inc[t]) begin
        stage2_d[t] = hit[t] ? 8'h00 : s2_inc[t];
      end else begin
        stage2_d[t] = stage2_q[t];
      end

      if (rise[t]) begin
        cnt_d[t] = 4'h0;
      end else if (rd_clr[t]) begin
        cnt_d[t] = hit[t] ? 4'h1 : 4'h0;
      end else if (hit[t]) begin
        cnt_d[t] = cnt_q[t] + 4'h1;
      end else begin
        cnt_d[t] = cnt_q[t];
      end
    end
  end

  // S-side read mux; unselected or write-only addresses return 0.
  always_comb begin
    rdata = 8'h00;
    if (s_sel) begin
      case (reg_idx)
        4'h2:                   rdata = dspaddr_q;
        4'h3:                   rdata = dsp_rdata;
        4'h4, 4'h5, 4'h6, 4'h7: rdata = in_q[reg_idx[1:0]];
        4'h8:                   rdata = aux0_q;
        4'h9:                   rdata = aux1_q;
        4'hD:                   rdata = {4'h0, cnt_q[0]};
        4'hE:                   rdata = {4'h0, cnt_q[1]};
        4'hF:                   rdata = {4'h0, cnt_q[2]};
        default:                rdata = 8'h00;
      endcase
    end else begin
      rdata = 8'h00;
    end
  end

  assign s_rdata   = rdata;
  assign m_rdata   = out_q[m_port];
  assign dsp_addr  = dspaddr_q;
  assign dsp_write = dsp_write_q;
  assign dsp_wdata = dsp_wdata_q;
  assign ipl_en    = control_q[7];

  // State update; reset overrides every same-cycle access.
  always_ff @(posedge clk) begin
    if (reset) begin
      test_q      <= 8'h00;
      control_q   <= 8'hB0;
      dspaddr_q   <= 8'h00;
      aux0_q      <= 8'h00;
      aux1_q      <= 8'h00;
      presc_q     <= '0;
      dsp_write_q <= 1'b0;
      dsp_wdata_q <= 8'h00;
      for (int p = 0; p < 4; p++) begin
        in_q[p]  <= 8'h00;
        out_q[p] <= 8'h00;
      end
      for (int t = 0; t < 3; t++) begin
        target_q[t] <= 8'h00;
        stage2_q[t] <= 8'h00;
        cnt_q[t]    <= 4'h0;
      end
    end else begin
      test_q      <= test_d;
      control_q   <= control_d;
      dspaddr_q   <= dspaddr_d;
      aux0_q      <= aux0_d;
      aux1_q      <= aux1_d;
      presc_q     <= presc_d;
      dsp_write_q <= dsp_write_d;
      dsp_wdata_q <= dsp_wdata_d;
      for (int p = 0; p < 4; p++) begin
        in_q[p]  <= in_d[p];
        out_q[p] <= out_d[p];
      end
      for (int t = 0; t < 3; t++) begin
        target_q[t] <= target_d[t];
        stage2_q[t] <= stage2_d[t];
        cnt_q[t]    <= cnt_d[t];
      end
    end
  end

endmodule

// File: tb/tb_s_smp_io.sv
// Self-checking bench for s_smp_io: register vector table plus
// hand-written sequences for ports, DSP link and timers.
`timescale 1ns/1ps
module tb_s_smp_io;

  localparam int T01 = 128;
  localparam int T2  = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_en;
  logic [15:0] s_addr;
  logic        s_read;
  logic        s_write;
  logic [7:0]  s_wdata;
  logic [7:0]  s_rdata;
  logic        s_sel;
  logic [1:0]  m_port;
  logic        m_read;
  logic        m_write;
  logic [7:0]  m_wdata;
  logic [7:0]  m_rdata;
  logic [7:0]  dsp_addr;
  logic        dsp_write;
  logic [7:0]  dsp_wdata;
  logic [7:0]  dsp_rdata;
  logic        ipl_en;

  s_smp_io #(.T01_DIV(T01), .T2_DIV(T2)) dut (
    .clk(clk), .reset(reset), .cpu_en(cpu_en),
    .s_addr(s_addr), .s_read(s_read), .s_write(s_write), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_sel(s_sel),
    .m_port(m_port), .m_read(m_read), .m_write(m_write), .m_wdata(m_wdata),
    .m_rdata(m_rdata),
    .dsp_addr(dsp_addr), .dsp_write(dsp_write), .dsp_wdata(dsp_wdata),
    .dsp_rdata(dsp_rdata), .ipl_en(ipl_en)
  );

  always #5 clk = ~clk;

  // Count of cpu_en edges since reset: the phase of the free-running prescaler.
  int en_cnt;
  always @(posedge clk) begin
    if (reset) en_cnt <= 0;
    else if (cpu_en) en_cnt <= en_cnt + 1;
  end

  typedef struct { string name; logic [7:0] exp; } sb_t;
  sb_t sb_q[$];

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  data;
    logic [7:0]  exp;
  } vec_t;
  vec_t vecs [0:14];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sb_check(input logic [7:0] act);
    sb_t e;
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_empty: got %h expected none", act);
    end else begin
      e = sb_q.pop_front();
      chk(e.name, act, e.exp);
    end
  endtask

  // All tasks are entered and left 1 ns after a rising edge.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic s_wr(input logic [15:0] a, input logic [7:0] d, input logic en = 1'b1);
    cpu_en  = en;
    s_addr  = a;
    s_wdata = d;
    s_write = 1'b1;
    @(posedge clk);
    #1;
    s_write = 1'b0;
    cpu_en  = 1'b1;
    s_addr  = 16'h0000;
  endtask

  task automatic s_rd(input logic [15:0] a, input logic [7:0] exp, input string name);
    cpu_en = 1'b1;
    s_addr = a;
    s_read = 1'b1;
    sb_q.push_back('{name, exp});
    @(negedge clk);
    sb_check(s_rdata);
    @(posedge clk);
    #1;
    s_read = 1'b0;
    s_addr = 16'h0000;
  endtask

  task automatic m_rd(input logic [1:0] p, input logic [7:0] exp, input string name);
    m_port = p;
    m_read = 1'b1;
    sb_q.push_back('{name, exp});
    @(negedge clk);
    sb_check(m_rdata);
    @(posedge clk);
    #1;
    m_read = 1'b0;
  endtask

  task automatic m_wr(input logic [1:0] p, input logic [7:0] d);
    m_port  = p;
    m_wdata = d;
    m_write = 1'b1;
    @(posedge clk);
    #1;
    m_write = 1'b0;
  endtask

  // Advance until the next edge is the one where the prescaler phase is p.
  task automatic wait_phase(input int p);
    int guard = 0;
    while (((en_cnt % T01) != p) && (guard < 1024)) begin
      idle(1);
      guard++;
    end
    if (guard >= 1024) begin
      total++;
      bad++;
      $display("FAIL wait_phase: got timeout expected phase %0d", p);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cpu_en = 1'b1; s_addr = 16'h0000; s_read = 1'b0;
    s_write = 1'b0; s_wdata = 8'h00; m_port = 2'd0; m_read = 1'b0;
    m_write = 1'b1; m_wdata = 8'h55; dsp_rdata = 8'hA5;

    vecs = '{
      '{1'b1, 16'h00F8, 8'h3C, 8'h00}, '{1'b0, 16'h00F8, 8'h00, 8'h3C},
      '{1'b1, 16'h00F9, 8'hA7, 8'h00}, '{1'b0, 16'h00F9, 8'h00, 8'hA7},
      '{1'b1, 16'h00F0, 8'h5A, 8'h00}, '{1'b0, 16'h00F0, 8'h00, 8'h00},
      '{1'b1, 16'h00F2, 8'h12, 8'h00}, '{1'b0, 16'h00F2, 8'h00, 8'h12},
      '{1'b1, 16'h00FB, 8'h55, 8'h00}, '{1'b0, 16'h00FB, 8'h00, 8'h00},
      '{1'b0, 16'h00F1, 8'h00, 8'h00}, '{1'b1, 16'h10F8, 8'hFF, 8'h00},
      '{1'b0, 16'h00F8, 8'h00, 8'h3C}, '{1'b0, 16'h01F9, 8'h00, 8'h00},
      '{1'b1, 16'h00F7, 8'hE1, 8'h00}
    };

    // Reset held for three edges while the main CPU writes port 0.
    idle(3);
    reset = 1'b0;
    m_write = 1'b0;
    chk("rst_ipl_en", {7'd0, ipl_en}, 8'h01);
    chk("rst_dsp_write", {7'd0, dsp_write}, 8'h00);
    chk("rst_dsp_addr", dsp_addr, 8'h00);
    s_rd(16'h00F1, 8'h00, "rst_F1");
    s_rd(16'h00FD, 8'h00, "rst_FD");
    s_rd(16'h00F4, 8'h00, "rst_beats_mwrite");
    m_rd(2'd0, 8'h00, "rst_m_rdata0");

    // Register vectors
    for (int i = 0; i < 15; i++) begin
      if (vecs[i].wr) s_wr(vecs[i].addr, vecs[i].data);
      else            s_rd(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d", i));
    end
    m_rd(2'd3, 8'hE1, "out_latch3");
    s_addr = 16'h10F8; #1;
    chk("s_sel_low", {7'd0, s_sel}, 8'h00);
    s_addr = 16'h00FF; #1;
    chk("s_sel_high", {7'd0, s_sel}, 8'h01);
    idle(1);

    // Writes without cpu_en are ignored.
    s_wr(16'h00F8, 8'h99, 1'b0);
    s_rd(16'h00F8, 8'h3C, "no_cpu_en_write");

    // Mailbox ports and CONTROL clears
    m_wr(2'd1, 8'h5A);
    s_rd(16'h00F5, 8'h5A, "in_latch1");
    s_wr(16'h00F6, 8'hC3);
    m_rd(2'd2, 8'hC3, "out_latch2");
    s_wr(16'h00F1, 8'h10);
    s_rd(16'h00F5, 8'h00, "clear_ports01");
    chk("ipl_en_off", {7'd0, ipl_en}, 8'h00);
    m_wr(2'd0, 8'h11);
    m_wr(2'd1, 8'h22);
    m_port = 2'd0; m_wdata = 8'h77; m_write = 1'b1;
    s_wr(16'h00F1, 8'h10);
    m_write = 1'b0;
    s_rd(16'h00F4, 8'h77, "mwrite_beats_clear");
    s_rd(16'h00F5, 8'h00, "clear_other_port");

    // DSP link
    s_wr(16'h00F2, 8'h4C);
    s_wr(16'h00F3, 8'h99);
    @(negedge clk);
    chk("dsp_write_pulse", {7'd0, dsp_write}, 8'h01);
    chk("dsp_addr", dsp_addr, 8'h4C);
    chk("dsp_wdata", dsp_wdata, 8'h99);
    @(negedge clk);
    chk("dsp_write_end", {7'd0, dsp_write}, 8'h00);
    @(posedge clk); #1;
    s_rd(16'h00F3, 8'hA5, "dsp_rdata");

    // Timer 0, target 2: four stage-1 ticks give two output counts.
    s_wr(16'h00FA, 8'h02);
    s_wr(16'h00F1, 8'h01);
    idle(4 * T01);
    s_rd(16'h00FD, 8'h02, "t0_count");
    s_rd(16'h00FD, 8'h00, "t0_reread");

    // Read-clear coinciding with an increment (target 1).
    s_wr(16'h00FA, 8'h01);
    s_wr(16'h00F1, 8'h00);
    wait_phase(0);
    s_wr(16'h00F1, 8'h01);
    for (int k = 0; k < 3; k++) begin
      wait_phase(T01 - 1);
      idle(1);
    end
    wait_phase(T01 - 1);
    s_rd(16'h00FD, 8'h03, "coincide_old");
    s_rd(16'h00FD, 8'h01, "coincide_left1");
    s_rd(16'h00FD, 8'h00, "coincide_clear");

    // Timer 2, target 0 (256): seventeen output counts wrap to 1.
    s_wr(16'h00FC, 8'h00);
    s_wr(16'h00F1, 8'h04);
    idle(256 * T2 * 17);
    s_rd(16'h00FF, 8'h01, "t2_wrap");

    // Reset while timers are counting.
    s_wr(16'h00F1, 8'h03);
    idle(400);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    s_rd(16'h00FD, 8'h00, "rst_mid_t0");
    s_rd(16'h00FE, 8'h00, "rst_mid_t1");
    s_rd(16'h00FF, 8'h00, "rst_mid_t2");
    s_rd(16'h00F2, 8'h00, "rst_mid_dspaddr");
    m_rd(2'd2, 8'h00, "rst_mid_out2");
    chk("rst_mid_ipl_en", {7'd0, ipl_en}, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
